// File: rtl/lsu_bus_initiator.sv
// Load/store initiator for the req/gnt data-RAM protocol: one access in flight, fault screening at accept.
// Optional grant-wait timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_initiator #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned SIZE_BYTES     = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        req_o,
    input  logic        gnt_i,
    output logic        ce_o,
    output logic        we_o,
    output logic [1:0]  hb_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic        accept;
    logic        f3_ok;
    logic        misaligned;
    logic        out_of_window;
    logic        fault;
    logic [31:0] offset;
    logic        timeout;

    assign accept = (state == IDLE) && valid_i;

    always_comb begin
        f3_ok = (funct3_i inside {3'b000, 3'b001, 3'b010}) ||
                (!we_i && (funct3_i inside {3'b100, 3'b101}));
        misaligned = ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                     ((funct3_i[1:0] == 2'b01) && addr_i[0]);
        offset        = addr_i - BASE_ADDR;
        out_of_window = (offset >= SIZE_BYTES);
        fault         = !f3_ok || misaligned || out_of_window;
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Fires in the last permitted REQ cycle, i.e. when the increment would reach the limit.
    assign timeout = (state == REQ) && !gnt_i &&
                     ((32'(wait_cnt) + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == REQ) && !gnt_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (valid_i) begin
                    state_next = fault ? RESP : REQ;
                end
            end
            REQ: begin
                if (gnt_i || timeout) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        req_o   = (state == REQ);
        ce_o    = (state == REQ);
        done_o  = (state == RESP);
        err_o   = (state == RESP) && err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            funct3_q <= '0;
            err_q    <= 1'b0;
            we_o     <= 1'b0;
            hb_o     <= '0;
            addr_o   <= '0;
            wdata_o  <= '0;
            rdata_o  <= '0;
        end else if (accept) begin
            funct3_q <= funct3_i;
            err_q    <= fault;
            we_o     <= we_i;
            hb_o     <= funct3_i[1:0];
            addr_o   <= addr_i;
            wdata_o  <= wdata_i;
        end else if (state == REQ) begin
            if (gnt_i) begin
                if (!we_o) begin
                    // RAM returns sign-extended data; unsigned loads strip the upper bits.
                    unique case (funct3_q)
                        3'b100:  rdata_o <= {24'b0, rdata_i[7:0]};
                        3'b101:  rdata_o <= {16'b0, rdata_i[15:0]};
                        default: rdata_o <= rdata_i;
                    endcase
                end
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
